// File: rtl/fir_pkg.sv
// fir_pkg: shared encodings for the FIR sequencer.
// Tag kinds, dag ring selects, FSM states and the tag bundle.
package fir_pkg;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_SWR  = 2'b01;
    localparam logic [1:0] ACC_SRD  = 2'b10;
    localparam logic [1:0] ACC_CRD  = 2'b11;

    localparam logic [2:0] CB_SWR  = 3'd0;
    localparam logic [2:0] CB_SRD  = 3'd1;
    localparam logic [2:0] CB_COEF = 3'd2;

    typedef logic [3:0] fir_st_t;

    localparam fir_st_t ST_UNCFG = 4'd0;
    localparam fir_st_t ST_CFG0  = 4'd1;
    localparam fir_st_t ST_CFG1  = 4'd2;
    localparam fir_st_t ST_CFG2  = 4'd3;
    localparam fir_st_t ST_IDLE  = 4'd4;
    localparam fir_st_t ST_WADDR = 4'd5;
    localparam fir_st_t ST_TAP_S = 4'd6;
    localparam fir_st_t ST_TAP_C = 4'd7;
    localparam fir_st_t ST_SKIP  = 4'd8;
    localparam fir_st_t ST_FLUSH = 4'd9;

    typedef struct packed {
        logic [1:0] kind;
        logic       clr;
        logic       en;
        logic       ov;
    } tag_t;

endpackage

// File: rtl/fir_seq_if.sv
// fir_seq_if: command bus from the FIR sequencer to one dag.
// master drives ring programming and read strobes.
interface fir_seq_if;

    logic        dag_we;
    logic        dag_re;
    logic [2:0]  dag_cbs;
    logic [15:0] dag_base;
    logic [11:0] dag_len;
    logic        dag_sign;
    logic [2:0]  dag_expt;

    modport master (
        output dag_we, dag_re, dag_cbs, dag_base,
        output dag_len, dag_sign, dag_expt
    );

    modport slave (
        input dag_we, dag_re, dag_cbs, dag_base,
        input dag_len, dag_sign, dag_expt
    );

endinterface

// File: rtl/fir_seq_tag_delay.sv
// tag_delay: DEPTH-stage shift register for the address tag.
// Keeps kind/mac/out_valid aligned with the dag address output.
module tag_delay
    import fir_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t d,
    output tag_t q
);

    tag_t sr [DEPTH];

    // Shift tags forward one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_seq.sv
// fir_seq: sequencer for one FIR output step.
// Programs three dag rings, then walks sample/coef reads per input.
module fir_seq
    import fir_pkg::*;
#(
    parameter int DAG_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [11:0] cfg_ntaps,
    input  logic [15:0] cfg_sbase,
    input  logic [15:0] cfg_cbase,
    output logic        cfg_busy,
    output logic        cfg_err,
    input  logic        smp_valid,
    output logic        smp_ready,
    fir_seq_if.master   dag,
    output logic [1:0]  acc_kind,
    output logic        mac_clr,
    output logic        mac_en,
    output logic        out_valid
);

    localparam int FL_W = (DAG_LAT > 1) ? $clog2(DAG_LAT) : 1;
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(DAG_LAT - 1);

    fir_st_t st, st_n;
    logic [11:0] n_q, n_d;
    logic [15:0] sb_q, sb_d, cb_q, cb_d;
    logic [11:0] tap_q, tap_n;
    logic [FL_W-1:0] fl_q, fl_n;

    logic accept, cfg_ok, cfg_go, cfg_bad, last_tap;

    logic        we_d, re_d;
    logic [2:0]  cbs_d;
    logic [15:0] base_d;
    logic [11:0] len_d;
    tag_t        t_d, t_q, t_o;

    assign accept   = (st == ST_IDLE) && smp_valid && smp_ready;
    assign cfg_ok   = ((st == ST_UNCFG) || (st == ST_IDLE))
                    && cfg_start && !accept;
    assign cfg_go   = cfg_ok && (cfg_ntaps != 12'd0);
    assign cfg_bad  = cfg_ok && (cfg_ntaps == 12'd0);
    assign last_tap = (tap_q == n_q - 12'd1);

    assign n_d  = cfg_go ? cfg_ntaps : n_q;
    assign sb_d = cfg_go ? cfg_sbase : sb_q;
    assign cb_d = cfg_go ? cfg_cbase : cb_q;

    // Next state, tap counter and flush counter.
    always_comb begin
        st_n  = st;
        tap_n = tap_q;
        fl_n  = fl_q;
        case (st)
            ST_UNCFG: if (cfg_go) st_n = ST_CFG0;
            ST_IDLE: begin
                if (accept)      st_n = ST_WADDR;
                else if (cfg_go) st_n = ST_CFG0;
            end
            ST_CFG0:  st_n = ST_CFG1;
            ST_CFG1:  st_n = ST_CFG2;
            ST_CFG2:  st_n = ST_IDLE;
            ST_WADDR: begin
                st_n  = ST_TAP_S;
                tap_n = '0;
            end
            ST_TAP_S: st_n = ST_TAP_C;
            ST_TAP_C: begin
                if (last_tap) begin
                    st_n = ST_SKIP;
                end else begin
                    st_n  = ST_TAP_S;
                    tap_n = tap_q + 12'd1;
                end
            end
            ST_SKIP: begin
                st_n = ST_FLUSH;
                fl_n = '0;
            end
            ST_FLUSH: begin
                if (fl_q == FL_LAST) st_n = ST_IDLE;
                else                 fl_n = fl_q + FL_W'(1);
            end
            default: st_n = ST_UNCFG;
        endcase
    end

    // Decode the state being entered into dag commands and issue tag.
    always_comb begin
        we_d   = 1'b0;
        re_d   = 1'b0;
        cbs_d  = CB_SWR;
        base_d = '0;
        len_d  = '0;
        t_d    = '0;
        unique case (1'b1)
            st_n == ST_CFG0: begin
                we_d   = 1'b1;
                cbs_d  = CB_SWR;
                base_d = sb_d;
                len_d  = n_d;
            end
            st_n == ST_CFG1: begin
                we_d   = 1'b1;
                cbs_d  = CB_SRD;
                base_d = sb_d;
                len_d  = n_d;
            end
            st_n == ST_CFG2: begin
                we_d   = 1'b1;
                cbs_d  = CB_COEF;
                base_d = cb_d;
                len_d  = n_d;
            end
            st_n == ST_WADDR: begin
                re_d   = 1'b1;
                cbs_d  = CB_SWR;
                t_d.kind = ACC_SWR;
            end
            st_n == ST_TAP_S: begin
                re_d   = 1'b1;
                cbs_d  = CB_SRD;
                t_d.kind = ACC_SRD;
            end
            st_n == ST_TAP_C: begin
                re_d   = 1'b1;
                cbs_d  = CB_COEF;
                t_d.kind = ACC_CRD;
                t_d.en   = 1'b1;
                t_d.clr  = (tap_n == 12'd0);
            end
            st_n == ST_SKIP: begin
                re_d   = 1'b1;
                cbs_d  = CB_SRD;
                t_d.ov = 1'b1;
            end
            default: ;
        endcase
    end

    // State and latched configuration.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st    <= ST_UNCFG;
            tap_q <= '0;
            fl_q  <= '0;
            n_q   <= '0;
            sb_q  <= '0;
            cb_q  <= '0;
        end else begin
            st    <= st_n;
            tap_q <= tap_n;
            fl_q  <= fl_n;
            n_q   <= n_d;
            sb_q  <= sb_d;
            cb_q  <= cb_d;
        end
    end

    // Registered outputs toward dag and the handshake side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dag.dag_we   <= 1'b0;
            dag.dag_re   <= 1'b0;
            dag.dag_cbs  <= '0;
            dag.dag_base <= '0;
            dag.dag_len  <= '0;
            t_q          <= '0;
            smp_ready    <= 1'b0;
            cfg_busy     <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            dag.dag_we   <= we_d;
            dag.dag_re   <= re_d;
            dag.dag_cbs  <= cbs_d;
            dag.dag_base <= base_d;
            dag.dag_len  <= len_d;
            t_q          <= t_d;
            smp_ready    <= (st_n == ST_IDLE);
            cfg_busy     <= (st_n != ST_IDLE) && (st_n != ST_UNCFG);
            cfg_err      <= cfg_bad;
        end
    end

    assign dag.dag_sign = 1'b0;
    assign dag.dag_expt = 3'd0;

    tag_delay #(
        .DEPTH (DAG_LAT)
    ) u_tag (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (t_q),
        .q     (t_o)
    );

    assign acc_kind  = t_o.kind;
    assign mac_clr   = t_o.clr;
    assign mac_en    = t_o.en;
    assign out_valid = t_o.ov;

endmodule

// File: tb/tb_fir_seq.sv
// tb_fir_seq: randomized bench for fir_seq with a behavioural dag
// and a per-cycle expectation model built from the tap schedule.
module tb_fir_seq;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [11:0] cfg_ntaps = '0;
    logic [15:0] cfg_sbase = '0;
    logic [15:0] cfg_cbase = '0;
    logic        cfg_busy, cfg_err;
    logic        smp_valid = 1'b0;
    logic        smp_ready;
    logic [1:0]  acc_kind;
    logic        mac_clr, mac_en, out_valid;

    fir_seq_if dag_bus ();

    fir_seq #(.DAG_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_ntaps (cfg_ntaps),
        .cfg_sbase (cfg_sbase),
        .cfg_cbase (cfg_cbase),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .dag       (dag_bus),
        .acc_kind  (acc_kind),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    always @(posedge clk) cyc++;

    // behavioural dag: three rings, +1 wrap, one cycle latency
    logic [15:0] d_base [3];
    int          d_len  [3] = '{0, 0, 0};
    int          d_ptr  [3] = '{0, 0, 0};
    logic [15:0] d_addr = '0;

    always @(posedge clk) begin
        int i;
        i = int'(dag_bus.dag_cbs);
        if (dag_bus.dag_we === 1'b1 && i < 3) begin
            d_base[i] = dag_bus.dag_base;
            d_len[i]  = int'(dag_bus.dag_len);
            d_ptr[i]  = 0;
        end
        if (dag_bus.dag_re === 1'b1 && i < 3 && d_len[i] > 0) begin
            d_addr   <= d_base[i] + 16'(d_ptr[i]);
            d_ptr[i]  = (d_ptr[i] + 1) % d_len[i];
        end
    end

    // expectation model, keyed by cycle number
    logic [1:0]  e_kind  [int];
    logic [15:0] e_addr  [int];
    bit          e_clr   [int];
    bit          e_en    [int];
    bit          e_ov    [int];
    logic [2:0]  e_re    [int];
    logic [2:0]  e_we    [int];
    logic [15:0] e_wbase [int];
    logic [11:0] e_wlen  [int];
    bit          e_busy  [int];
    bit          e_err   [int];

    bit cfgd = 0;
    int ready_at = 0;
    int m_n = 1, m_sb = 0, m_cb = 0, m_idx = 0;
    int last_acc = 0;

    function automatic bit exp_ready(int c);
        return cfgd && (c >= ready_at);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     nm, cyc, got, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (cyc >= 1) begin
            logic [1:0] ek;
            ek = e_kind.exists(cyc) ? e_kind[cyc] : ACC_NONE;
            chk("acc_kind", 32'(acc_kind), 32'(ek));
            chk("mac_clr", 32'(mac_clr), 32'(e_clr.exists(cyc)));
            chk("mac_en", 32'(mac_en), 32'(e_en.exists(cyc)));
            chk("out_valid", 32'(out_valid), 32'(e_ov.exists(cyc)));
            chk("dag_re", 32'(dag_bus.dag_re), 32'(e_re.exists(cyc)));
            chk("dag_we", 32'(dag_bus.dag_we), 32'(e_we.exists(cyc)));
            chk("smp_ready", 32'(smp_ready), 32'(exp_ready(cyc)));
            chk("cfg_busy", 32'(cfg_busy), 32'(e_busy.exists(cyc)));
            chk("cfg_err", 32'(cfg_err), 32'(e_err.exists(cyc)));
            chk("dag_sign", 32'(dag_bus.dag_sign), 32'd0);
            chk("dag_expt", 32'(dag_bus.dag_expt), 32'd0);
            if (ek != ACC_NONE)
                chk("dag_addr", 32'(d_addr), 32'(e_addr[cyc]));
            if (e_re.exists(cyc))
                chk("re_cbs", 32'(dag_bus.dag_cbs), 32'(e_re[cyc]));
            if (e_we.exists(cyc)) begin
                chk("we_cbs", 32'(dag_bus.dag_cbs), 32'(e_we[cyc]));
                chk("we_base", 32'(dag_bus.dag_base),
                    32'(e_wbase[cyc]));
                chk("we_len", 32'(dag_bus.dag_len), 32'(e_wlen[cyc]));
            end
        end
    end

    // monitor for the back-to-back N=1 checks
    int          ov_q [$];
    logic [15:0] swr_q [$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_q.push_back(cyc);
        if (acc_kind === ACC_SWR) swr_q.push_back(d_addr);
    end

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset(int r);
        for (int c = r; c < r + 9000; c++) begin
            e_kind.delete(c);  e_addr.delete(c);
            e_clr.delete(c);   e_en.delete(c);
            e_ov.delete(c);    e_re.delete(c);
            e_we.delete(c);    e_wbase.delete(c);
            e_wlen.delete(c);  e_busy.delete(c);
            e_err.delete(c);
        end
        cfgd = 0;
        ready_at = 0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (cfgd && !exp_ready(cyc)) begin
            nxt();
            g++;
            if (g > 10000) begin
                chk("wait_idle_timeout", 32'd1, 32'd0);
                return;
            end
        end
    endtask

    task automatic do_cfg(int n, logic [15:0] sb, logic [15:0] cb);
        int c;
        c = cyc + 1;
        cfg_start = 1'b1;
        cfg_ntaps = 12'(n);
        cfg_sbase = sb;
        cfg_cbase = cb;
        if (n == 0) begin
            e_err[c] = 1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                e_we[c+i]    = 3'(i);
                e_wbase[c+i] = (i == 2) ? cb : sb;
                e_wlen[c+i]  = 12'(n);
                e_busy[c+i]  = 1;
            end
            cfgd = 1;
            ready_at = c + 3;
            m_n = n; m_sb = int'(sb); m_cb = int'(cb); m_idx = 0;
        end
        nxt();
        cfg_start = 1'b0;
        cfg_ntaps = 12'($urandom_range(0, 4095));
    endtask

    // one output step: N taps over rings that advance N+1 per sample
    task automatic push_sample(int a);
        int nn, s;
        nn = m_n;
        s = m_idx;
        for (int c = a; c <= a + 2*nn + 2; c++) e_busy[c] = 1;
        e_re[a]     = CB_SWR;
        e_kind[a+1] = ACC_SWR;
        e_addr[a+1] = 16'(m_sb + (s % nn));
        for (int k = 0; k < nn; k++) begin
            e_re[a+1+2*k]   = CB_SRD;
            e_re[a+2+2*k]   = CB_COEF;
            e_kind[a+2+2*k] = ACC_SRD;
            e_addr[a+2+2*k] = 16'(m_sb + ((s + k) % nn));
            e_kind[a+3+2*k] = ACC_CRD;
            e_addr[a+3+2*k] = 16'(m_cb + k);
            e_en[a+3+2*k]   = 1;
            if (k == 0) e_clr[a+3] = 1;
        end
        e_re[a+2*nn+1] = CB_SRD;
        e_ov[a+2*nn+2] = 1;
        ready_at = a + 2*nn + 3;
        m_idx++;
        last_acc = a;
    endtask

    task automatic send_samples(int cnt);
        smp_valid = 1'b1;
        for (int s = 0; s < cnt; s++) begin
            int g = 0;
            while (!exp_ready(cyc)) begin
                nxt();
                g++;
                if (g > 10000) begin
                    chk("accept_timeout", 32'd1, 32'd0);
                    smp_valid = 1'b0;
                    return;
                end
            end
            push_sample(cyc + 1);
            nxt();
        end
        smp_valid = 1'b0;
    endtask

    task automatic lit_seq(logic [1:0] lk [7], logic [15:0] la [7]);
        int a;
        a = last_acc;
        for (int i = 0; i < 7; i++) begin
            nxt();
            chk("lit_kind", 32'(acc_kind), 32'(lk[i]));
            chk("lit_addr", 32'(d_addr), 32'(la[i]));
            chk("lit_clr", 32'(mac_clr), 32'(cyc == a + 3));
        end
        nxt();
        chk("lit_ov", 32'(out_valid), 32'd1);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  lk [7];
        logic [15:0] la [7];

        repeat (3) nxt();
        chk("rst_ready", 32'(smp_ready), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_kind", 32'(acc_kind), 32'd0);
        rst_n = 1'b1;

        // unconfigured: valid must not be accepted
        smp_valid = 1'b1;
        repeat (6) nxt();
        smp_valid = 1'b0;
        nxt();

        // zero taps rejected, then N=3 directed sequence
        do_cfg(0, 16'h0100, 16'h0200);
        nxt();
        do_cfg(3, 16'h0100, 16'h0200);
        wait_idle();
        do_cfg(0, 16'h0300, 16'h0400);
        wait_idle();
        nxt();
        send_samples(1);
        lk = '{ACC_SWR, ACC_SRD, ACC_CRD, ACC_SRD,
               ACC_CRD, ACC_SRD, ACC_CRD};
        la = '{16'h0100, 16'h0100, 16'h0200, 16'h0101,
               16'h0201, 16'h0102, 16'h0202};
        lit_seq(lk, la);
        wait_idle();
        send_samples(1);
        la = '{16'h0101, 16'h0101, 16'h0200, 16'h0102,
               16'h0201, 16'h0100, 16'h0202};
        lit_seq(lk, la);

        // cfg_start while processing is ignored
        wait_idle();
        send_samples(1);
        cfg_start = 1'b1;
        cfg_ntaps = 12'd0;
        nxt();
        cfg_ntaps = 12'd5;
        nxt();
        cfg_start = 1'b0;

        // N=1, three back-to-back samples
        wait_idle();
        do_cfg(1, 16'h0100, 16'h0200);
        wait_idle();
        ov_q.delete();
        swr_q.delete();
        send_samples(3);
        wait_idle();
        nxt();
        chk("n1_ov_count", 32'(ov_q.size()), 32'd3);
        chk("n1_swr_count", 32'(swr_q.size()), 32'd3);
        if (ov_q.size() == 3) begin
            chk("n1_period0", 32'(ov_q[1] - ov_q[0]), 32'd6);
            chk("n1_period1", 32'(ov_q[2] - ov_q[1]), 32'd6);
        end
        foreach (swr_q[i]) chk("n1_waddr", 32'(swr_q[i]), 32'h0100);

        // reset during TAP_C with N=4
        do_cfg(4, 16'h0100, 16'h0200);
        wait_idle();
        send_samples(1);
        nxt();
        nxt();
        rst_n = 1'b0;
        model_reset(cyc + 1);
        nxt();
        chk("mid_rst_re", 32'(dag_bus.dag_re), 32'd0);
        chk("mid_rst_kind", 32'(acc_kind), 32'd0);
        chk("mid_rst_busy", 32'(cfg_busy), 32'd0);
        rst_n = 1'b1;
        smp_valid = 1'b1;
        repeat (10) nxt();
        smp_valid = 1'b0;
        do_cfg(4, 16'h0100, 16'h0200);
        wait_idle();
        send_samples(2);

        // randomized configurations and sample streams
        for (int it = 0; it < 25; it++) begin
            int n;
            wait_idle();
            n = (it % 5 == 0) ? $urandom_range(1, 40)
                              : $urandom_range(1, 6);
            do_cfg(n, 16'($urandom_range(0, 16'hE000)),
                   16'($urandom_range(0, 16'hE000)));
            wait_idle();
            repeat ($urandom_range(0, 3)) nxt();
            send_samples($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 1) begin
                cfg_start = 1'b1;
                cfg_ntaps = 12'($urandom_range(0, 3));
                nxt();
                cfg_start = 1'b0;
            end
            wait_idle();
            repeat ($urandom_range(0, 4)) nxt();
        end

        // largest tap count
        wait_idle();
        do_cfg(4095, 16'h1000, 16'h8000);
        wait_idle();
        send_samples(1);
        wait_idle();
        repeat (4) nxt();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
